// File: rtl/if_prefetch_unit_pkg.sv
// Types and constants shared between the fetch front end and the IF/ID register.
package Pipe_Buf_Reg_PKG;

    localparam int unsigned FetchAddrW = 32;
    localparam int unsigned FetchInsW  = 32;

    // addi x0, x0, 0: the bubble decode inserts when no entry is valid
    localparam logic [31:0] InstrNop = 32'h0000_0013;

    typedef struct packed {
        logic [FetchAddrW-1:0] pc;
        logic [FetchInsW-1:0]  instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_unit_sync_fifo.sv
// Synchronous FIFO with registered storage, flush, and an occupancy count.
module sync_fifo
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned Depth   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  entry_t                 data_i,
    input  logic                   pop_i,
    output entry_t                 data_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    entry_t            mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    // Depth is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PtrW'(push_i);
            rd_ptr_d = rd_ptr_q + PtrW'(pop_i);
            count_d  = count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction prefetcher: pipelined req/gnt/rvalid fetch into a small queue feeding decode.
module if_prefetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INS_W    = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INS_W-1:0]  imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INS_W-1:0]  if_instr
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INS_W-1:0]  instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CntW-1:0]   pending_q, pending_d;
    logic [CntW-1:0]   drop_q, drop_d;
    logic [CntW-1:0]   fifo_count;
    logic [CntW:0]     used_credits;
    logic [CntW:0]     inflight;
    logic              gnt_fire, rsp_live, rsp_stale;
    logic              push, pop, flush;
    logic [ADDR_W-1:0] target_pc;
    entry_t            push_entry, head_entry;
    logic              unused_redirect_lsbs;

    // Queued entries reserve credits too, so a stalled queue can never overflow.
    assign used_credits = {1'b0, fifo_count} + {1'b0, pending_q};
    assign inflight     = {1'b0, pending_q} + {1'b0, drop_q};
    assign imem_req     = !reset && !redirect && (used_credits < (CntW + 1)'(DEPTH))
                          && (inflight < (CntW + 1)'(DEPTH));
    assign imem_addr    = fetch_pc_q;

    assign gnt_fire  = imem_req && imem_gnt;
    assign rsp_stale = imem_rvalid && (drop_q != '0);
    assign rsp_live  = imem_rvalid && (drop_q == '0);

    assign target_pc            = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        pending_d  = pending_q;
        drop_d     = drop_q;
        if (redirect) begin
            // Every in-flight fetch becomes stale; one returning now is already gone.
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            pending_d  = '0;
            drop_d     = drop_q + pending_q - CntW'(imem_rvalid);
        end else begin
            if (gnt_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            end
            if (rsp_live) begin
                resp_pc_d = resp_pc_q + ADDR_W'(4);
            end
            pending_d = pending_q + CntW'(gnt_fire) - CntW'(rsp_live);
            drop_d    = drop_q - CntW'(rsp_stale);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            pending_q  <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
        end
    end

    assign push       = rsp_live && !redirect && !reset;
    assign pop        = (fifo_count != '0) && !stall && !redirect && !reset;
    assign flush      = redirect || reset;
    assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};

    sync_fifo #(
        .entry_t (entry_t),
        .Depth   (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .count_o (fifo_count)
    );

    assign if_valid = !reset && (fifo_count != '0);
    assign if_pc    = if_valid ? head_entry.pc : '0;
    assign if_instr = if_valid ? head_entry.instr : '0;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: in-order memory model plus an expected-entry scoreboard.
module tb_if_prefetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    typedef struct {
        logic [31:0] data;
        int          ready;
    } mem_rsp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mem_rsp_t    mq[$];
    exp_t        exq[$];
    int          n_vec;
    int          n_err;
    int          n_pops;
    int          cyc;
    int          lat;
    logic        gnt_en;
    logic [31:0] m_pc;

    if_prefetch_unit #(
        .ADDR_W   (32),
        .INS_W    (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {~a[15:0], a[15:0] ^ 16'h5A3C};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory side of the cycle: grant per gnt_en, return the oldest due response.
    task automatic drive_cycle();
        mem_rsp_t r;
        imem_gnt = gnt_en;
        if (!reset && mq.size() > 0 && mq[0].ready <= cyc) begin
            r           = mq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = r.data;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
    endtask

    // Scoreboard update from the settled cycle, then advance to the next negedge.
    task automatic end_cycle();
        exp_t     e;
        mem_rsp_t r;
        if (reset) begin
            check("rst_req", {31'b0, imem_req}, 32'd0);
            check("rst_valid", {31'b0, if_valid}, 32'd0);
            check("rst_pc", if_pc, 32'd0);
            check("rst_instr", if_instr, 32'd0);
            mq.delete();
            exq.delete();
            m_pc = 32'h0;
        end else begin
            if (if_valid && !stall && !redirect) begin
                if (exq.size() == 0) begin
                    check("pop_unexpected", {31'b0, if_valid}, 32'd0);
                end else begin
                    e = exq.pop_front();
                    check("pop_pc", if_pc, e.pc);
                    check("pop_instr", if_instr, e.instr);
                    n_pops++;
                end
            end
            if (imem_req) begin
                check("req_addr", imem_addr, m_pc);
            end
            if (imem_req && imem_gnt) begin
                r.data  = mem_data(imem_addr);
                r.ready = cyc + lat;
                mq.push_back(r);
                e.pc    = m_pc;
                e.instr = mem_data(m_pc);
                exq.push_back(e);
                m_pc    = m_pc + 32'd4;
            end
            if (redirect) begin
                exq.delete();
                m_pc = redirect_pc & ~32'd3;
            end
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic step();
        drive_cycle();
        end_cycle();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        gnt_en   = 1'b1;
        lat      = 1;
        step();
        reset  = 1'b0;
        n_pops = 0;
    endtask

    task automatic wait_valid(input int max_cycles, input string tag);
        for (int i = 0; i < max_cycles && !if_valid; i++) begin
            step();
        end
        check(tag, {31'b0, if_valid}, 32'd1);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        n_pops      = 0;
        cyc         = 0;
        lat         = 1;
        gnt_en      = 1'b1;
        m_pc        = 32'h0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        @(negedge clock);
        step();
        step();
        reset  = 1'b0;
        n_pops = 0;

        // Streaming: one instruction per cycle, first valid two cycles after the first grant.
        for (int c = 0; c < 12; c++) begin
            drive_cycle();
            if (c == 0) check("t1_addr0", imem_addr, 32'h0);
            if (c < 2) check("t1_valid_early", {31'b0, if_valid}, 32'd0);
            if (c == 2) check("t1_valid_c2", {31'b0, if_valid}, 32'd1);
            end_cycle();
        end
        check("t1_pops", n_pops, 32'd10);

        // Stall with full queue: requests stop, nothing is lost after release.
        do_reset();
        wait_valid(6, "t2_first_valid");
        stall = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive_cycle();
            check("t2_hold_pc", if_pc, 32'h0);
            end_cycle();
        end
        drive_cycle();
        check("t2_req_low", {31'b0, imem_req}, 32'd0);
        check("t2_valid", {31'b0, if_valid}, 32'd1);
        end_cycle();
        stall = 1'b0;
        for (int c = 0; c < 8; c++) step();
        check("t2_drained", {31'b0, (n_pops >= 5)}, 32'd1);

        // Redirect with pc 8 and 12 still in flight.
        do_reset();
        for (int c = 0; c < 10 && imem_addr != 32'h8; c++) step();
        lat = 5;
        step();
        step();
        gnt_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        drive_cycle();
        check("t3_req_low", {31'b0, imem_req}, 32'd0);
        end_cycle();
        redirect = 1'b0;
        gnt_en   = 1'b1;
        lat      = 1;
        drive_cycle();
        check("t3_addr_target", imem_addr, 32'h40);
        end_cycle();
        wait_valid(14, "t3_valid");
        check("t3_first_pc", if_pc, 32'h40);
        step();
        wait_valid(4, "t3_valid2");
        check("t3_second_pc", if_pc, 32'h44);

        // Grant withheld: address held, advances only after the grant.
        do_reset();
        gnt_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_cycle();
            check("t4_req_held", {31'b0, imem_req}, 32'd1);
            check("t4_addr_held", imem_addr, 32'h0);
            end_cycle();
        end
        gnt_en = 1'b1;
        step();
        drive_cycle();
        check("t4_addr_next", imem_addr, 32'h4);
        end_cycle();

        // Redirect coinciding with the only live response; misaligned target.
        do_reset();
        step();
        gnt_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        gnt_en   = 1'b1;
        drive_cycle();
        check("t5_empty", {31'b0, if_valid}, 32'd0);
        check("t5_req", {31'b0, imem_req}, 32'd1);
        check("t5_addr", imem_addr, 32'h100);
        end_cycle();
        wait_valid(6, "t5_valid");
        check("t5_pc", if_pc, 32'h100);

        // Reset in the middle of a stalled stream with three entries queued.
        do_reset();
        wait_valid(6, "t6_first_valid");
        stall = 1'b1;
        step();
        step();
        drive_cycle();
        check("t6_queued_head", if_pc, 32'h0);
        end_cycle();
        reset = 1'b1;
        stall = 1'b0;
        step();
        reset = 1'b0;
        drive_cycle();
        check("t6_valid_after", {31'b0, if_valid}, 32'd0);
        check("t6_req_after", {31'b0, imem_req}, 32'd1);
        check("t6_addr_after", imem_addr, 32'h0);
        end_cycle();
        for (int c = 0; c < 4; c++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
